glb_banked_sram: RTL and testbench
==================================

Name: glb_banked_sram

Overview:
- Parametrised, banked global-buffer (GLB) memory model that supersedes the fixed 64 KB single-port SRAM model.
- Provides one read port and one write port per cycle, each with a valid/ready handshake.
- Read latency is configurable and pipelined; writes use active-low byte masks.
- Same-bank read/write conflicts are resolved by a fairness arbiter.
- Sits between the token engine (GLB reads of weight, ifmap, ipsum and bias) and the opsum drain path (GLB writes).

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH_WORDS, 16384, total words (16384 × 32 b = 64 KB).
- NUM_BANKS, 4, power of two; word-interleaved banks.
- RD_LAT, 1, read latency in cycles from accepted request to data; legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_valid_i  in  1  read request valid
- rd_req_ready_o  out  1  read request accepted this cycle
- rd_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- rd_data_valid_o  out  1  read data valid strobe
- rd_data_o  out  DATA_W  read data
- wr_req_valid_i  in  1  write request valid
- wr_req_ready_o  out  1  write request accepted this cycle
- wr_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- wr_data_i  in  DATA_W  write data
- wr_bweb_i  in  DATA_W/8  active-low byte write enable (0 = write that byte)
- addr_err_o  out  1  sticky out-of-range flag

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low, on rst_n.
  - Reset values: rd_data_valid_o=0, rd_data_o=0, addr_err_o=0, read pipeline cleared, fairness flag = write-priority.
  - Memory array contents are NOT reset.
- Address decode:
  - word = addr[ADDR_W-1:2]
  - bank = word % NUM_BANKS
  - row = word / NUM_BANKS
  - Out of range when word >= DEPTH_WORDS.
- Ready logic (combinational from valids and the fairness flag):
  - No conflict (different banks, or only one valid): both ready = 1.
  - Conflict (both valid, same bank): exactly one port is ready.
    - Fairness flag = write-priority: write wins, read stalls, flag flips to read-priority.
    - Fairness flag = read-priority: read wins, write stalls, flag flips to write-priority.
  - Flag changes only on conflict cycles.
  - No combinational path from ready to valid is required of the master. The master holds request fields stable while valid && !ready.
- Write:
  - On wr_req_valid_i && wr_req_ready_o, each byte i with wr_bweb_i[i]==0 is written at the clock edge.
  - Out-of-range write: no array change; addr_err_o set.
- Read:
  - On rd_req_valid_i && rd_req_ready_o, the request enters an RD_LAT-deep pipeline.
  - rd_data_valid_o pulses exactly RD_LAT cycles after acceptance, with the row contents sampled at the acceptance edge.
  - A same-address write accepted in the same cycle cannot coexist with the read (same bank), so there is no read/write hazard.
  - A write accepted in a later cycle never alters data already in flight.
  - Out-of-range read: returns 0, valid still pulses, addr_err_o set.
  - Back-to-back reads sustain one per cycle; the pipeline never backpressures.
- rd_data_o holds its last value when rd_data_valid_o=0.
- addr_err_o stays high until reset.
- Reset mid-operation: in-flight reads are discarded (no valid pulse); any write in the reset cycle is dropped.

Test Plan:
- Write 0xDEADBEEF at addr 0x0000, bweb=4'b0000; then read 0x0000 with RD_LAT=1 -> valid exactly 1 cycle after accept, data 0xDEADBEEF.
- Write 0x11223344 to 0x0010 with bweb=4'b1100, prior content 0xAAAAAAAA -> subsequent read returns 0xAAAA3344.
- RD_LAT=3, reads issued on 4 consecutive cycles to 0x0,0x4,0x8,0xC -> 4 consecutive valid pulses starting 3 cycles after the first accept, in order.
- Read 0x0000 and write 0x0010 continuously (same bank with NUM_BANKS=4) -> ready alternates write,read,write,read; neither port starves; read data reflects the writes accepted before each read's acceptance.
- Read 0x0000 and write 0x0004 simultaneously (different banks) -> both ready=1 every cycle, no flag change.
- Read addr 0x0001_0000 (word 16384, out of range) -> data 0, valid pulses, addr_err_o=1 and stays 1; assert rst_n=0 with 2 reads in flight (RD_LAT=3) -> no valid pulses, addr_err_o=0.

Source files
------------

// File: rtl/glb_banked_sram_if.sv
// Read/write request and response bundle for the banked global buffer.
// Signal names follow the memory's point of view (slave side).
interface glb_banked_sram_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  rd_req_valid_i;
   logic                  rd_req_ready_o;
   logic [ADDR_W-1:0]     rd_addr_i;
   logic                  rd_data_valid_o;
   logic [DATA_W-1:0]     rd_data_o;
   logic                  wr_req_valid_i;
   logic                  wr_req_ready_o;
   logic [ADDR_W-1:0]     wr_addr_i;
   logic [DATA_W-1:0]     wr_data_i;
   logic [DATA_W/8-1:0]   wr_bweb_i;
   logic                  addr_err_o;

   modport slave (
      input  rd_req_valid_i, rd_addr_i, wr_req_valid_i, wr_addr_i, wr_data_i, wr_bweb_i,
      output rd_req_ready_o, rd_data_valid_o, rd_data_o, wr_req_ready_o, addr_err_o
   );

   modport master (
      output rd_req_valid_i, rd_addr_i, wr_req_valid_i, wr_addr_i, wr_data_i, wr_bweb_i,
      input  rd_req_ready_o, rd_data_valid_o, rd_data_o, wr_req_ready_o, addr_err_o
   );
endinterface

// File: rtl/glb_banked_sram.sv
// Word-interleaved banked GLB memory: one read and one write port per cycle,
// pipelined reads, byte-masked writes, alternating priority on bank conflicts.
//
// state   | meaning
// PRIO_WR | write wins the next same-bank conflict
// PRIO_RD | read wins the next same-bank conflict
module glb_banked_sram #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 16384,
   parameter int NUM_BANKS   = 4,
   parameter int RD_LAT      = 1,
   parameter int ADDR_W      = 32
) (
   input logic               clk,
   input logic               rst_n,
   glb_banked_sram_if.slave  bus
);
   localparam int NB_BYTES = DATA_W / 8;
   localparam int BANK_SH  = $clog2(NUM_BANKS);
   localparam int BANK_W   = (NUM_BANKS > 1) ? BANK_SH : 1;
   localparam int ROWS     = DEPTH_WORDS / NUM_BANKS;
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WORD_W   = ADDR_W - 2;

   typedef enum logic {PRIO_WR, PRIO_RD} prio_e;
   prio_e prio_q, prio_d;

   logic [DATA_W-1:0] mem [NUM_BANKS][ROWS];

   logic [WORD_W-1:0] rd_word, wr_word;
   logic [BANK_W-1:0] rd_bank, wr_bank;
   logic [ROW_W-1:0]  rd_row, wr_row;
   logic              rd_ok, wr_ok;
   logic              conflict, rd_rdy, wr_rdy, rd_fire, wr_fire;
   logic              unused_addr_lsb;

   logic [RD_LAT-1:0] vld_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];
   logic              err_q;

   assign rd_word = bus.rd_addr_i[ADDR_W-1:2];
   assign wr_word = bus.wr_addr_i[ADDR_W-1:2];
   assign unused_addr_lsb = ^{bus.rd_addr_i[1:0], bus.wr_addr_i[1:0]};

   // Low word bits select the bank, the rest select the row inside it.
   assign rd_bank = BANK_W'(rd_word & WORD_W'(NUM_BANKS - 1));
   assign wr_bank = BANK_W'(wr_word & WORD_W'(NUM_BANKS - 1));
   assign rd_row  = ROW_W'(rd_word >> BANK_SH);
   assign wr_row  = ROW_W'(wr_word >> BANK_SH);
   assign rd_ok   = rd_word < WORD_W'(DEPTH_WORDS);
   assign wr_ok   = wr_word < WORD_W'(DEPTH_WORDS);

   assign conflict = bus.rd_req_valid_i && bus.wr_req_valid_i && (rd_bank == wr_bank);

   always_comb begin
      prio_d = prio_q;
      rd_rdy = 1'b1;
      wr_rdy = 1'b1;
      if (conflict) begin
         if (prio_q == PRIO_WR) begin
            rd_rdy = 1'b0;
            prio_d = PRIO_RD;
         end else begin
            wr_rdy = 1'b0;
            prio_d = PRIO_WR;
         end
      end
   end

   assign rd_fire = bus.rd_req_valid_i && rd_rdy;
   assign wr_fire = bus.wr_req_valid_i && wr_rdy;

   // Array is not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (wr_fire && wr_ok && rst_n) begin
         for (int b = 0; b < NB_BYTES; b++) begin
            if (!bus.wr_bweb_i[b]) mem[wr_bank][wr_row][b*8 +: 8] <= bus.wr_data_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= PRIO_WR;
         vld_q  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      end else begin
         prio_q   <= prio_d;
         vld_q[0] <= rd_fire;
         if (rd_fire) dat_q[0] <= rd_ok ? mem[rd_bank][rd_row] : '0;
         // Stages only advance on valid so the last stage holds its data between pulses.
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
         if ((rd_fire && !rd_ok) || (wr_fire && !wr_ok)) err_q <= 1'b1;
      end
   end

   assign bus.rd_req_ready_o  = rd_rdy;
   assign bus.wr_req_ready_o  = wr_rdy;
   assign bus.rd_data_valid_o = vld_q[RD_LAT-1];
   assign bus.rd_data_o       = dat_q[RD_LAT-1];
   assign bus.addr_err_o      = err_q;
endmodule

// File: tb/tb_glb_banked_sram.sv
// Scoreboard bench for glb_banked_sram: identical stimulus drives an RD_LAT=1
// and an RD_LAT=3 instance; monitors check data and arrival cycle of each read.
module tb_glb_banked_sram;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   prio_m = 1'b0;

   typedef struct { logic [31:0] data; int due; } exp_t;
   exp_t q1[$];
   exp_t q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   glb_banked_sram_if #(.ADDR_W(32), .DATA_W(32)) m1();
   glb_banked_sram_if #(.ADDR_W(32), .DATA_W(32)) m3();

   assign m3.rd_req_valid_i = m1.rd_req_valid_i;
   assign m3.rd_addr_i      = m1.rd_addr_i;
   assign m3.wr_req_valid_i = m1.wr_req_valid_i;
   assign m3.wr_addr_i      = m1.wr_addr_i;
   assign m3.wr_data_i      = m1.wr_data_i;
   assign m3.wr_bweb_i      = m1.wr_bweb_i;

   glb_banked_sram #(.DATA_W(32), .DEPTH_WORDS(16384), .NUM_BANKS(4), .RD_LAT(1), .ADDR_W(32))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));
   glb_banked_sram #(.DATA_W(32), .DEPTH_WORDS(16384), .NUM_BANKS(4), .RD_LAT(3), .ADDR_W(32))
      dut3 (.clk(clk), .rst_n(rst_n), .bus(m3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock of stimulus; expected readiness comes from the fairness model.
   task automatic step(input logic rv, input logic [31:0] ra, input logic [31:0] rexp,
                       input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] wb, output logic racc, output logic wacc);
      logic conf, er, ew;
      @(negedge clk); #1;
      m1.rd_req_valid_i = rv;
      m1.rd_addr_i      = ra;
      m1.wr_req_valid_i = wv;
      m1.wr_addr_i      = wa;
      m1.wr_data_i      = wd;
      m1.wr_bweb_i      = wb;
      #1;
      conf = rv && wv && (ra[3:2] == wa[3:2]);
      er = !conf || prio_m;
      ew = !conf || !prio_m;
      if (rv) begin
         chk("rd_ready_lat1", {31'd0, m1.rd_req_ready_o}, {31'd0, er});
         chk("rd_ready_lat3", {31'd0, m3.rd_req_ready_o}, {31'd0, er});
      end
      if (wv) begin
         chk("wr_ready_lat1", {31'd0, m1.wr_req_ready_o}, {31'd0, ew});
         chk("wr_ready_lat3", {31'd0, m3.wr_req_ready_o}, {31'd0, ew});
      end
      racc = rv && er;
      wacc = wv && ew;
      if (conf) prio_m = !prio_m;
      if (racc) begin
         q1.push_back('{rexp, cyc + 1});
         q3.push_back('{rexp, cyc + 3});
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      logic a, b;
      repeat (n) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'hF, a, b);
   endtask

   task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wb);
      logic a, b;
      step(1'b0, 32'h0, 32'h0, 1'b1, wa, wd, wb, a, b);
   endtask

   task automatic rd(input logic [31:0] ra, input logic [31:0] rexp);
      logic a, b;
      step(1'b1, ra, rexp, 1'b0, 32'h0, 32'h0, 4'hF, a, b);
   endtask

   task automatic chk_err(input string nm, input logic exp);
      chk({nm, "_lat1"}, {31'd0, m1.addr_err_o}, {31'd0, exp});
      chk({nm, "_lat3"}, {31'd0, m3.addr_err_o}, {31'd0, exp});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (m1.rd_data_valid_o) begin
         if (q1.size() == 0) chk("rd1_spurious_valid", {31'd0, m1.rd_data_valid_o}, 32'd0);
         else begin
            e = q1.pop_front();
            chk("rd1_data", m1.rd_data_o, e.data);
            chk("rd1_cycle", cyc, e.due);
         end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
         chk("rd1_missing_valid", {31'd0, m1.rd_data_valid_o}, 32'd1);
         void'(q1.pop_front());
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (m3.rd_data_valid_o) begin
         if (q3.size() == 0) chk("rd3_spurious_valid", {31'd0, m3.rd_data_valid_o}, 32'd0);
         else begin
            e = q3.pop_front();
            chk("rd3_data", m3.rd_data_o, e.data);
            chk("rd3_cycle", cyc, e.due);
         end
      end else if (q3.size() != 0 && q3[0].due <= cyc) begin
         chk("rd3_missing_valid", {31'd0, m3.rd_data_valid_o}, 32'd1);
         void'(q3.pop_front());
      end
   end

   initial begin
      logic        racc, wacc;
      int          nr, nw;
      logic [31:0] wd, cur0;

      m1.rd_req_valid_i = 1'b0;
      m1.rd_addr_i      = '0;
      m1.wr_req_valid_i = 1'b0;
      m1.wr_addr_i      = '0;
      m1.wr_data_i      = '0;
      m1.wr_bweb_i      = 4'hF;
      repeat (3) @(negedge clk);
      chk("reset_valid_lat1", {31'd0, m1.rd_data_valid_o}, 32'd0);
      chk("reset_valid_lat3", {31'd0, m3.rd_data_valid_o}, 32'd0);
      chk("reset_data_lat1", m1.rd_data_o, 32'd0);
      chk("reset_data_lat3", m3.rd_data_o, 32'd0);
      chk_err("reset_err", 1'b0);
      #1 rst_n = 1'b1;

      // Full-word write then read back
      wr(32'h0000, 32'hDEADBEEF, 4'b0000);
      rd(32'h0000, 32'hDEADBEEF);
      idle(4);

      // Byte mask: only the two low bytes are replaced
      wr(32'h0010, 32'hAAAAAAAA, 4'b0000);
      wr(32'h0010, 32'h11223344, 4'b1100);
      rd(32'h0010, 32'hAAAA3344);
      idle(4);

      // Four back-to-back reads across all banks
      wr(32'h0004, 32'h44444444, 4'b0000);
      wr(32'h0008, 32'h88888888, 4'b0000);
      wr(32'h000C, 32'hCCCCCCCC, 4'b0000);
      rd(32'h0000, 32'hDEADBEEF);
      rd(32'h0004, 32'h44444444);
      rd(32'h0008, 32'h88888888);
      rd(32'h000C, 32'hCCCCCCCC);
      idle(5);

      // Different banks: both ports accepted every cycle
      nr = 0; nw = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'h0000, 32'hDEADBEEF, 1'b1, 32'h0004, 32'h50000000 + k, 4'b0000, racc, wacc);
         nr += int'(racc); nw += int'(wacc);
      end
      chk("diffbank_reads", nr, 32'd4);
      chk("diffbank_writes", nw, 32'd4);
      rd(32'h0004, 32'h50000003);
      idle(4);

      // Same bank, different rows: write first, then strict alternation
      nr = 0; nw = 0; wd = 32'h10000000;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 32'h0000, 32'hDEADBEEF, 1'b1, 32'h0010, wd, 4'b0000, racc, wacc);
         if (k == 0) chk("alt_first_is_write", {31'd0, wacc}, 32'd1);
         nr += int'(racc);
         if (wacc) begin nw++; wd++; end
      end
      chk("alt_reads", nr, 32'd4);
      chk("alt_writes", nw, 32'd4);
      idle(1);
      rd(32'h0010, 32'h10000003);
      idle(4);

      // Same address: each read sees the write accepted just before it
      cur0 = 32'hDEADBEEF; wd = 32'h20000000; nr = 0; nw = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 32'h0000, cur0, 1'b1, 32'h0000, wd, 4'b0000, racc, wacc);
         nr += int'(racc);
         if (wacc) begin nw++; cur0 = wd; wd++; end
      end
      chk("same_addr_reads", nr, 32'd4);
      chk("same_addr_writes", nw, 32'd4);
      idle(4);

      // Out-of-range read returns zero and sets the sticky flag
      chk_err("err_before_oor", 1'b0);
      rd(32'h0001_0000, 32'h0);
      idle(4);
      chk_err("err_after_oor_rd", 1'b1);
      idle(3);
      chk_err("err_sticky", 1'b1);

      // Reset with reads in flight in the latency-3 instance
      rd(32'h0000, 32'h20000003);
      rd(32'h0004, 32'h50000003);
      @(negedge clk); #1;
      rst_n = 1'b0;
      m1.rd_req_valid_i = 1'b0;
      m1.wr_req_valid_i = 1'b0;
      q1.delete();
      q3.delete();
      prio_m = 1'b0;
      @(negedge clk);
      chk_err("err_in_reset", 1'b0);
      chk("rst_valid_lat3", {31'd0, m3.rd_data_valid_o}, 32'd0);
      chk("rst_data_lat3", m3.rd_data_o, 32'd0);
      #1 rst_n = 1'b1;
      idle(5);
      chk_err("err_after_reset", 1'b0);

      // Out-of-range write must not alias onto row 0 of bank 0
      wr(32'h0001_0000, 32'hBAD0BAD0, 4'b0000);
      idle(1);
      chk_err("err_after_oor_wr", 1'b1);
      rd(32'h0000, 32'h20000003);
      idle(6);

      chk("drain_q_lat1", q1.size(), 32'd0);
      chk("drain_q_lat3", q3.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=<%0d", cyc, 20000);
      $fatal(1, "timeout");
   end
endmodule
